// File: rtl/msi_bus_pkg.sv
// Shared types and constants for the MSI snoopy bus transaction sequencer.
package msi_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_RSVD = 2'b11
  } bus_msg_t;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StSnoop,
    StFlush,
    StMem,
    StData,
    StDone
  } ctrl_state_t;

  localparam logic [15:0] DATA_FOR_READS  = 16'hCAFE;
  localparam logic [15:0] DATA_FOR_WRITES = 16'hDEAD;

  // Reserved messages behave like upgrades: no data phase.
  function automatic logic msg_has_data(bus_msg_t msg);
    return (msg == BUS_RD) || (msg == BUS_RDX);
  endfunction

endpackage

// File: rtl/msi_bus_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping upward.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  localparam int unsigned SumW = IdxW + 1;

  logic [SumW-1:0] sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      sum = {1'b0, ptr_i} + SumW'(i);
      if (sum >= SumW'(NumReq)) begin
        sum = sum - SumW'(NumReq);
      end
      cand = sum[IdxW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_bus_ctrl.sv
// MSI snoopy bus sequencer: round-robin grant, one snoop cycle, then flush/memory/no-data completion.
// Optional protocol checking on err_o is enabled by defining MSI_BUS_ERR_CHECK_EN.
module msi_bus_ctrl
  import msi_bus_pkg::*;
#(
  parameter int unsigned NUM_PROCS       = 4,
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned CACHE_LINE_SIZE = 128,
  parameter int unsigned MEM_LAT         = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_PROCS-1:0]                 req_i,
  input  logic [2*NUM_PROCS-1:0]               msg_i,
  input  logic [ADDR_SIZE*NUM_PROCS-1:0]       addr_i,
  output logic [NUM_PROCS-1:0]                 gnt_o,
  output logic                                 bus_valid_o,
  output logic [1:0]                           bus_msg_o,
  output logic [ADDR_SIZE-1:0]                 bus_addr_o,
  input  logic [NUM_PROCS-1:0]                 flush_i,
  input  logic [CACHE_LINE_SIZE*NUM_PROCS-1:0] flush_data_i,
  output logic                                 data_valid_o,
  output logic [CACHE_LINE_SIZE-1:0]           data_o,
  output logic [NUM_PROCS-1:0]                 done_o,
  output logic                                 err_o
);

  localparam int unsigned IdxW = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1;
  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  ctrl_state_t          state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d, owner_q, owner_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  bus_msg_t             msg_q, msg_d;
  logic [NUM_PROCS-1:0] gnt_q, gnt_d, done_q, done_d;
  logic                 bus_valid_q, bus_valid_d, data_valid_q, data_valid_d;
  logic [1:0]           bus_msg_q, bus_msg_d;
  logic [ADDR_SIZE-1:0] bus_addr_q, bus_addr_d;
  logic [CACHE_LINE_SIZE-1:0] data_q, data_d;

  logic [NUM_PROCS-1:0] arb_gnt, owner_oh, flush_m;
  logic [IdxW-1:0]      arb_idx, fl_idx;
  logic                 arb_valid;
  logic [1:0]           owner_msg;

  rr_arbiter #(
    .NumReq (NUM_PROCS),
    .IdxW   (IdxW)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign owner_oh  = {{(NUM_PROCS-1){1'b0}}, 1'b1} << owner_q;
  assign flush_m   = flush_i & ~owner_oh;
  assign owner_msg = msg_i[2*owner_q +: 2];

  always_comb begin
    fl_idx = '0;
    for (int i = NUM_PROCS - 1; i >= 0; i--) begin
      if (flush_m[i]) fl_idx = IdxW'(i);
    end
  end

  // Outputs are computed for the state being entered so they register in step with it.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    msg_d        = msg_q;
    gnt_d        = '0;
    bus_valid_d  = 1'b0;
    bus_msg_d    = '0;
    bus_addr_d   = '0;
    data_valid_d = 1'b0;
    data_d       = '0;
    done_d       = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          gnt_d   = arb_gnt;
          state_d = StGrant;
        end
      end
      StGrant: begin
        msg_d       = bus_msg_t'(owner_msg);
        bus_valid_d = 1'b1;
        bus_msg_d   = owner_msg;
        bus_addr_d  = addr_i[owner_q*ADDR_SIZE +: ADDR_SIZE];
        state_d     = StSnoop;
      end
      StSnoop: begin
        if (!msg_has_data(msg_q)) begin
          done_d  = owner_oh;
          state_d = StDone;
        end else if (flush_m != '0) begin
          data_valid_d = 1'b1;
          data_d       = flush_data_i[fl_idx*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
          state_d      = StFlush;
        end else begin
          cnt_d   = CntW'(MEM_LAT - 1);
          state_d = StMem;
        end
      end
      StMem: begin
        if (cnt_q == '0) begin
          data_valid_d = 1'b1;
          data_d       = (msg_q == BUS_RD) ? CACHE_LINE_SIZE'(DATA_FOR_READS)
                                           : CACHE_LINE_SIZE'(DATA_FOR_WRITES);
          state_d      = StData;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFlush, StData: begin
        done_d  = owner_oh;
        state_d = StDone;
      end
      StDone: begin
        ptr_d   = (owner_q == IdxW'(NUM_PROCS - 1)) ? '0 : owner_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      msg_q        <= BUS_RD;
      gnt_q        <= '0;
      bus_valid_q  <= 1'b0;
      bus_msg_q    <= '0;
      bus_addr_q   <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      msg_q        <= msg_d;
      gnt_q        <= gnt_d;
      bus_valid_q  <= bus_valid_d;
      bus_msg_q    <= bus_msg_d;
      bus_addr_q   <= bus_addr_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      done_q       <= done_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign bus_valid_o  = bus_valid_q;
  assign bus_msg_o    = bus_msg_q;
  assign bus_addr_o   = bus_addr_q;
  assign data_valid_o = data_valid_q;
  assign data_o       = data_q;
  assign done_o       = done_q;

`ifdef MSI_BUS_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == StSnoop) begin
      if ((flush_i & (flush_i - 1'b1)) != '0) err_d = 1'b1;
      if ((flush_i & owner_oh) != '0) err_d = 1'b1;
    end else if (flush_i != '0) begin
      err_d = 1'b1;
    end
    if (((gnt_q & (gnt_q - 1'b1)) != '0) || ((done_q & (done_q - 1'b1)) != '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_msi_bus_ctrl.sv
// Scoreboard bench for msi_bus_ctrl: stimulus pushes expected events, a negedge monitor pops them.
module tb_msi_bus_ctrl;

  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int CLS = 128;
  localparam int ML  = 4;
`ifdef MSI_BUS_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef enum int {EvGnt, EvBus, EvData, EvDone} ev_kind_t;
  typedef struct {
    ev_kind_t       kind;
    int             cyc;
    logic [CLS-1:0] val;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req = '0;
  logic [NP-1:0]     flush = '0;
  logic [2*NP-1:0]   msg = '0;
  logic [AW*NP-1:0]  addr = '0;
  logic [CLS*NP-1:0] fdata = '0;
  logic [NP-1:0]     gnt_o, done_o;
  logic              bus_valid_o, data_valid_o, err_o;
  logic [1:0]        bus_msg_o;
  logic [AW-1:0]     bus_addr_o;
  logic [CLS-1:0]    data_o;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  ev_t exp_q[$];

  msi_bus_ctrl #(
    .NUM_PROCS       (NP),
    .ADDR_SIZE       (AW),
    .CACHE_LINE_SIZE (CLS),
    .MEM_LAT         (ML)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .msg_i        (msg),
    .addr_i       (addr),
    .gnt_o        (gnt_o),
    .bus_valid_o  (bus_valid_o),
    .bus_msg_o    (bus_msg_o),
    .bus_addr_o   (bus_addr_o),
    .flush_i      (flush),
    .flush_data_i (fdata),
    .data_valid_o (data_valid_o),
    .data_o       (data_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic void push(input ev_kind_t k, input int c, input logic [CLS-1:0] v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(input ev_kind_t k, input logic [CLS-1:0] v);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: got 0x%0h at cycle %0d, required no event", k.name(), v, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc || e.val != v) begin
      $display("FAIL event_%s: got %s@%0d 0x%0h, required %s@%0d 0x%0h",
               e.kind.name(), k.name(), cyc, v, e.kind.name(), e.cyc, e.val);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk(input string name, input logic [CLS-1:0] act, input logic [CLS-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every asserted output must match the next expected event, including its cycle.
  always @(negedge clk) begin
    if (gnt_o != '0)  check_ev(EvGnt, CLS'(gnt_o));
    if (bus_valid_o)  check_ev(EvBus, CLS'({bus_msg_o, bus_addr_o}));
    if (data_valid_o) check_ev(EvData, data_o);
    if (done_o != '0) check_ev(EvDone, CLS'(done_o));
  end

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"}, CLS'(gnt_o), '0);
    chk({tag, "_bus_valid"}, CLS'(bus_valid_o), '0);
    chk({tag, "_bus_msg"}, CLS'(bus_msg_o), '0);
    chk({tag, "_bus_addr"}, CLS'(bus_addr_o), '0);
    chk({tag, "_data_valid"}, CLS'(data_valid_o), '0);
    chk({tag, "_data"}, data_o, '0);
    chk({tag, "_done"}, CLS'(done_o), '0);
    chk({tag, "_err"}, CLS'(err_o), '0);
  endtask

  // One transaction from cache idx; fl is driven during the snoop cycle only.
  task automatic run_txn(input int idx, input logic [1:0] m, input logic [AW-1:0] a,
                         input logic [NP-1:0] fl, input logic [CLS-1:0] exp_data);
    int c, d;
    logic [NP-1:0] fl_m;
    @(negedge clk);
    c = cyc;
    req[idx] = 1'b1;
    msg[2*idx +: 2] = m;
    addr[AW*idx +: AW] = a;
    fl_m = fl & ~(NP'(1) << idx);
    push(EvGnt, c + 1, CLS'(1) << idx);
    push(EvBus, c + 2, CLS'({m, a}));
    if (m == 2'b00 || m == 2'b01) begin
      if (fl_m != '0) begin
        push(EvData, c + 3, exp_data);
        d = c + 4;
      end else begin
        push(EvData, c + 3 + ML, exp_data);
        d = c + 4 + ML;
      end
    end else begin
      d = c + 3;
    end
    push(EvDone, d, CLS'(1) << idx);
    repeat (2) @(negedge clk);
    flush = fl;
    @(negedge clk);
    flush = '0;
    while (cyc < d) @(negedge clk);
    req[idx] = 1'b0;
  endtask

  initial begin
    int c;
    logic [AW-1:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    run_txn(2, 2'b00, 32'h40, '0, CLS'(16'hCAFE));
    run_txn(1, 2'b01, 32'h80, '0, CLS'(16'hDEAD));
    fdata[CLS*3 +: CLS] = CLS'(16'h1234);
    run_txn(0, 2'b01, 32'hC0, 4'b1000, CLS'(16'h1234));
    run_txn(1, 2'b10, 32'h100, '0, '0);
    run_txn(2, 2'b11, 32'h140, '0, '0);
    fdata[CLS*1 +: CLS] = CLS'(16'hAAAA);
    fdata[CLS*2 +: CLS] = CLS'(16'hBBBB);
    run_txn(0, 2'b00, 32'h180, 4'b0110, CLS'(16'hAAAA));
    @(negedge clk);
    chk("err_after_double_flush", CLS'(err_o), CLS'(EXP_ERR));
    repeat (3) @(negedge clk);
    chk("err_sticky", CLS'(err_o), CLS'(EXP_ERR));
    // The owner's own flush bit must not steer the transaction away from memory.
    run_txn(3, 2'b00, 32'h1C0, 4'b1000, CLS'(16'hCAFE));

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset2");

    // All caches request continuously: grants rotate 0,1,2,3,0.
    @(negedge clk);
    c = cyc;
    req = '1;
    for (int i = 0; i < NP; i++) begin
      msg[2*i +: 2] = 2'b10;
      addr[AW*i +: AW] = AW'(32'h1000 + i * 16);
    end
    for (int k = 0; k < 5; k++) begin
      a = AW'(32'h1000 + (k % NP) * 16);
      push(EvGnt, c + 4*k + 1, CLS'(1) << (k % NP));
      push(EvBus, c + 4*k + 2, CLS'({2'b10, a}));
      push(EvDone, c + 4*k + 3, CLS'(1) << (k % NP));
    end
    for (int k = 0; k < 5; k++) begin
      while (cyc < c + 4*k + 3) @(negedge clk);
      if (k == 4) req = '0;
      else req[k % NP] = 1'b0;
      @(negedge clk);
      if (k < 4) req[k % NP] = 1'b1;
    end

    // Reset while waiting on memory: no data or done may follow.
    @(negedge clk);
    c = cyc;
    req[1] = 1'b1;
    msg[3:2] = 2'b00;
    addr[63:32] = 32'h200;
    push(EvGnt, c + 1, CLS'(4'b0010));
    push(EvBus, c + 2, CLS'({2'b00, 32'h200}));
    while (cyc < c + 4) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_idle("midreset");
    rst = 1'b0;
    run_txn(3, 2'b10, 32'h240, '0, '0);

    repeat (4) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d unseen events, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
